// File: rtl/evcap_pkg.sv
// Shared types and default sizes for the event timestamp capture block.
// The top level uses these defaults for its parameters. EVCAP_SYNC_EN is the
// optional input-synchronizer build macro, consumed in event_timestamp_capture.sv.
package evcap_pkg;

  localparam int EVCAP_NUM_CH = 4;
  localparam int EVCAP_TS_W   = 16;
  localparam int EVCAP_DEPTH  = 8;

  // One captured event at the default sizes: which lines moved, when, and to what.
  typedef struct packed {
    logic [EVCAP_NUM_CH-1:0] mask;
    logic [EVCAP_TS_W-1:0]   ts;
    logic [EVCAP_NUM_CH-1:0] level;
  } evcap_rec_t;

  typedef enum logic {
    DISARMED = 1'b0,
    ARMED    = 1'b1
  } evcap_state_e;

endpackage

// File: rtl/event_timestamp_capture_if.sv
// Record stream from the capture block to a downstream checker/logger.
// master = capture block (producer), slave = consumer.
interface event_timestamp_capture_if #(
  parameter int NUM_CH = 4,
  parameter int TS_W   = 16,
  parameter int DEPTH  = 8
);
  logic                     ev_valid;
  logic                     ev_ready;
  logic [NUM_CH-1:0]        ev_mask;
  logic [TS_W-1:0]          ev_ts;
  logic [NUM_CH-1:0]        ev_level;
  logic [$clog2(DEPTH):0]   ev_count;
  logic                     overflow;

  modport master (
    output ev_valid, ev_mask, ev_ts, ev_level, ev_count, overflow,
    input  ev_ready
  );

  modport slave (
    input  ev_valid, ev_mask, ev_ts, ev_level, ev_count, overflow,
    output ev_ready
  );
endinterface

// File: rtl/evcap_fifo.sv
// Generic first-word fall-through FIFO. The head entry is visible on dout
// whenever empty is low. A push while full is accepted only if a pop happens
// in the same cycle; clr flushes everything and wins over push/pop.
module evcap_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   clr,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  output logic                   full,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             wr_en;
  logic             rd_en;

  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  // Storage array; no reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_en && !clr) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

endmodule

// File: rtl/event_timestamp_capture.sv
// Event timestamp capture: records every cycle in which any monitored line
// changes as {mask, timestamp, new levels} into a FWFT FIFO.
// Build option: define EVCAP_SYNC_EN to pass ch_in through a 2-flop
// synchronizer per bit (adds two cycles of latency).
module event_timestamp_capture
  import evcap_pkg::*;
#(
  parameter int NUM_CH = EVCAP_NUM_CH,
  parameter int TS_W   = EVCAP_TS_W,
  parameter int DEPTH  = EVCAP_DEPTH
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      clr,
  input  logic [NUM_CH-1:0]         ch_in,
  event_timestamp_capture_if.master ev_if
);
  localparam int REC_W = 2 * NUM_CH + TS_W;

  logic [NUM_CH-1:0]      sampled;
  logic [NUM_CH-1:0]      prev_q;
  logic [NUM_CH-1:0]      changed;
  logic [TS_W-1:0]        ts_q;
  evcap_state_e           state_q;
  logic                   overflow_q;
  logic                   push_req;
  logic                   pop_req;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [REC_W-1:0]       rec_din;
  logic [REC_W-1:0]       rec_dout;
  logic [$clog2(DEPTH):0] fifo_count;

`ifdef EVCAP_SYNC_EN
  logic [NUM_CH-1:0] sync1_q;
  logic [NUM_CH-1:0] sync2_q;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_sync
    // Two-flop synchronizer for one asynchronous input line.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        sync1_q[gi] <= 1'b0;
        sync2_q[gi] <= 1'b0;
      end else begin
        sync1_q[gi] <= ch_in[gi];
        sync2_q[gi] <= sync1_q[gi];
      end
    end
  end

  assign sampled = sync2_q;
`else
  assign sampled = ch_in;
`endif

  assign changed  = sampled ^ prev_q;
  assign pop_req  = !fifo_empty && ev_if.ev_ready && !clr;
  assign push_req = (state_q == ARMED) && (changed != '0) && !clr;
  assign rec_din  = {changed, ts_q, sampled};

  // Free-running timestamp; wraps silently, zeroed by clr.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)    ts_q <= '0;
    else if (clr) ts_q <= '0;
    else          ts_q <= ts_q + TS_W'(1);
  end

  // Arm FSM: the first cycle after reset/clr only learns the current levels.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= DISARMED;
      prev_q  <= '0;
    end else if (clr) begin
      state_q <= DISARMED;
    end else begin
      prev_q <= sampled;
      case (state_q)
        DISARMED: state_q <= ARMED;
        ARMED:    state_q <= ARMED;
        default:  state_q <= DISARMED;
      endcase
    end
  end

  // Sticky overflow: a record arrived while full with nothing leaving.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                      overflow_q <= 1'b0;
    else if (clr)                                   overflow_q <= 1'b0;
    else if (push_req && fifo_full && !pop_req)     overflow_q <= 1'b1;
  end

  evcap_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (clr),
    .push  (push_req),
    .din   (rec_din),
    .full  (fifo_full),
    .pop   (pop_req),
    .dout  (rec_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Record fields are forced to zero while empty so reset values are clean.
  assign ev_if.ev_valid = !fifo_empty;
  assign ev_if.ev_mask  = fifo_empty ? '0 : rec_dout[REC_W-1 -: NUM_CH];
  assign ev_if.ev_ts    = fifo_empty ? '0 : rec_dout[NUM_CH +: TS_W];
  assign ev_if.ev_level = fifo_empty ? '0 : rec_dout[NUM_CH-1:0];
  assign ev_if.ev_count = fifo_count;
  assign ev_if.overflow = overflow_q;

endmodule

// File: doc/event_timestamp_capture.md
Name: event_timestamp_capture

Overview:
- Timestamping monitor; the receiving end of timed stimulus generators.
- Watches NUM_CH single-bit lines and records every cycle in which any line changes.
- Each record holds {changed-channel mask, timestamp, new levels} and goes into a small FIFO.
- Simultaneous changes are reported as one record with several mask bits set; changes in successive cycles give separate records. This lets sequenced and parallel-scheduled events be told apart.
- A downstream checker or logger drains the FIFO over a valid/ready interface.

Parameters:
- NUM_CH, 4: number of monitored lines.
- TS_W, 16: timestamp counter width.
- DEPTH, 8: FIFO entries; power of two, ≥2.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rstn  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear: flush FIFO, zero timestamp, clear overflow, disarm.
- ch_in  input  NUM_CH  monitored lines.
- ev_valid  output  1  head record available.
- ev_ready  input  1  consumer accepts head record.
- ev_mask  output  NUM_CH  channels that changed.
- ev_ts  output  TS_W  timestamp of the change.
- ev_level  output  NUM_CH  ch_in value after the change.
- ev_count  output  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky: a record was dropped.

Behaviour:
- Reset (rstn=0, asynchronous) sets:
  - ev_valid=0, ev_mask=0, ev_ts=0, ev_level=0, ev_count=0, overflow=0.
  - Timestamp counter=0, prev register=0, state=DISARMED.
- Timestamp counter increments by 1 every cycle and wraps from 2^TS_W-1 to 0 silently. clr forces it to 0.
- State machine:
  - DISARMED: load prev<=ch_in (sampled value), generate no record, go to ARMED next cycle. This state is entered after reset and after clr.
  - ARMED: changed = sampled ^ prev; prev<=sampled every cycle.
  - If changed≠0, push {changed, ts, sampled}, where ts is the counter value in the detecting cycle.
- Latency: a change sampled at edge N gives ev_valid=1 after edge N (visible in cycle N+1), provided the FIFO was empty.
- Multiple bits changing in the same cycle produce exactly one record with all those bits set in the mask.
- FIFO:
  - First-word fall-through; outputs show the head entry while ev_valid=1.
  - Pop when ev_valid && ev_ready.
  - ev_valid=0 when empty. ev_mask/ev_ts/ev_level are don't-care when empty; the bench must not check them then.
- Full FIFO:
  - A push with no pop in the same cycle is dropped and overflow is set. overflow holds until clr or reset.
  - Push and pop in the same cycle while full: both succeed, count stays DEPTH, overflow is not set.
- Empty FIFO with a push: ev_valid rises the next cycle. ev_ready while empty is ignored.
- clr has priority over push and pop in the same cycle. The change in that cycle is discarded and the block returns to DISARMED.
- Reset asserted mid-operation discards all records immediately (asynchronous).

Optional Feature:
- Macro EVCAP_SYNC_EN.
- When defined: ch_in passes through a 2-flop synchronizer per bit before edge detection. "Sampled" means the synchronizer output; latency from a ch_in pin change to ev_valid becomes 3 cycles. Synchronizer flops reset to 0.
- When undefined: ch_in must be synchronous to clk and is sampled directly (latency 1 cycle, as above).

Decomposition:
- Package evcap_pkg:
  - Packed struct typedef evcap_rec_t with fields mask, ts, level, sized from package localparams that mirror the parameter defaults.
  - State enum {DISARMED, ARMED}.
- Sub-module evcap_fifo: generic FWFT FIFO (parameters WIDTH, DEPTH) with push/full/pop/empty/count. Top level holds the edge detect, counter, FSM and overflow logic.

Test Plan:
1. Reset with ch_in=4'b0011, release, hold for 10 cycles -> no record (DISARMED absorbs the initial level); ev_valid=0, overflow=0.
2. Sequential: bit0 rises at cycle 5, bit1 rises at cycle 10 -> two records: {mask=0001, ts=5, level=0001} then {mask=0010, ts=10, level=0011}.
3. Parallel: bits 0 and 1 rise in the same cycle 5 -> one record {mask=0011, ts=5, level=0011}.
4. ev_ready=0, toggle bit2 every cycle for 10 cycles -> 8 records held, ev_count=8, overflow=1. Then drain: 8 records with consecutive ts values, then ev_valid=0.
5. FIFO full, then push and pop in the same cycle -> count stays 8, overflow stays 0 (after clr). Then assert clr with a change pending -> count=0, ts=0, no record from that change.
6. TS_W=4: change at counter value 15 and again 2 cycles later -> ts=15 then ts=1 (wrap-around). With EVCAP_SYNC_EN, a change at cycle 5 gives ev_valid at cycle 8 and ts=7.
